// File: rtl/dcache_line_ctrl.sv
// dcache_line_ctrl: line fill / victim writeback engine between the dcache
// miss logic and the memory bus. It drives the data bank's full-line write
// port (bank_mem_wren) and reads dirty victims through its full-line output.
// All outputs are registered and change only at the clock edge.
module dcache_line_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_req,
  input  logic [14:0] miss_addr,
  input  logic [1:0]  victim_way,
  input  logic        victim_dirty,
  input  logic [8:0]  victim_tag,
  output logic        miss_ack,
  output logic        busy,
  output logic        err_way,
  output logic        err_timeout,
  output logic [14:0] bank_addr,
  output logic [1:0]  bank_way,
  output logic        bank_rden,
  output logic        bank_mem_wren,
  output logic [63:0] bank_wrdata,
  input  logic [63:0] bank_line,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVICT_RD,
    S_WB_REQ,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_INSTALL,
    S_DONE
  } state_t;

  // Last count value allowed in a wait state; reaching it aborts the miss.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      r_state;
  logic [11:0] r_line;        // miss line address (tag + index)
  logic [8:0]  r_vtag;        // victim tag
  logic [7:0]  r_cnt;         // cycles spent in the current memory-wait state
  logic        r_miss_ack;
  logic        r_busy;
  logic        r_err_way;
  logic        r_err_timeout;
  logic [14:0] r_bank_addr;
  logic [1:0]  r_bank_way;
  logic        r_bank_rden;
  logic        r_bank_mem_wren;
  logic [63:0] r_bank_wrdata;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [14:0] r_mem_addr;
  logic [63:0] r_mem_wdata;   // doubles as the writeback buffer

  logic [14:0] w_vline;
  logic [14:0] w_fline;
  logic        w_unused;

  assign w_vline  = {r_vtag, r_line[2:0], 3'b000};
  assign w_fline  = {r_line, 3'b000};
  // Byte offset within the line is irrelevant to a line engine.
  assign w_unused = ^miss_addr[2:0];

  // Miss FSM with registered Moore outputs and the memory-wait watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_line          <= '0;
      r_vtag          <= '0;
      r_cnt           <= '0;
      r_miss_ack      <= 1'b0;
      r_busy          <= 1'b0;
      r_err_way       <= 1'b0;
      r_err_timeout   <= 1'b0;
      r_bank_addr     <= '0;
      r_bank_way      <= '0;
      r_bank_rden     <= 1'b0;
      r_bank_mem_wren <= 1'b0;
      r_bank_wrdata   <= '0;
      r_mem_req       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
    end else begin
      r_miss_ack      <= 1'b0;
      r_err_way       <= 1'b0;
      r_bank_rden     <= 1'b0;
      r_bank_mem_wren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (miss_req) begin
            if (victim_way == 2'd3) begin
              r_err_way <= 1'b1;
            end else begin
              r_line     <= miss_addr[14:3];
              r_vtag     <= victim_tag;
              r_bank_way <= victim_way;
              r_busy     <= 1'b1;
              if (victim_dirty) begin
                r_state     <= S_EVICT_RD;
                r_bank_addr <= {victim_tag, miss_addr[5:3], 3'b000};
                r_bank_rden <= 1'b1;
              end else begin
                r_state    <= S_FILL_REQ;
                r_mem_req  <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= {miss_addr[14:3], 3'b000};
                r_cnt      <= '0;
              end
            end
          end
        end
        S_EVICT_RD: begin
          r_mem_wdata <= bank_line;
          r_state     <= S_WB_REQ;
          r_mem_req   <= 1'b1;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= w_vline;
          r_cnt       <= '0;
        end
        S_WB_REQ: begin
          if (mem_gnt) begin
            r_state    <= S_FILL_REQ;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_fline;
            r_cnt      <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_state       <= S_IDLE;
            r_err_timeout <= 1'b1;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_busy        <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_FILL_REQ: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            // Data may ride along with the grant; then the wait state is skipped.
            if (mem_rvalid) begin
              r_bank_wrdata   <= mem_rdata;
              r_bank_addr     <= w_fline;
              r_bank_mem_wren <= 1'b1;
              r_state         <= S_INSTALL;
            end else begin
              r_state <= S_FILL_WAIT;
              r_cnt   <= '0;
            end
          end else if (r_cnt == TO_LAST) begin
            r_state       <= S_IDLE;
            r_err_timeout <= 1'b1;
            r_mem_req     <= 1'b0;
            r_busy        <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_FILL_WAIT: begin
          if (mem_rvalid) begin
            r_bank_wrdata   <= mem_rdata;
            r_bank_addr     <= w_fline;
            r_bank_mem_wren <= 1'b1;
            r_state         <= S_INSTALL;
          end else if (r_cnt == TO_LAST) begin
            r_state       <= S_IDLE;
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_INSTALL: begin
          r_state    <= S_DONE;
          r_miss_ack <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign miss_ack      = r_miss_ack;
  assign busy          = r_busy;
  assign err_way       = r_err_way;
  assign err_timeout   = r_err_timeout;
  assign bank_addr     = r_bank_addr;
  assign bank_way      = r_bank_way;
  assign bank_rden     = r_bank_rden;
  assign bank_mem_wren = r_bank_mem_wren;
  assign bank_wrdata   = r_bank_wrdata;
  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_dcache_line_ctrl.sv
// Directed bench for dcache_line_ctrl with a small 8x3 bank model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dcache_line_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [14:0] miss_addr;
  logic [1:0]  victim_way;
  logic        victim_dirty;
  logic [8:0]  victim_tag;
  logic        miss_ack;
  logic        busy;
  logic        err_way;
  logic        err_timeout;
  logic [14:0] bank_addr;
  logic [1:0]  bank_way;
  logic        bank_rden;
  logic        bank_mem_wren;
  logic [63:0] bank_wrdata;
  logic [63:0] bank_line;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  logic [63:0] bankm [8][3];
  int unsigned n_vec  = 0;
  int unsigned n_err  = 0;
  int unsigned n_ack  = 0;
  int unsigned n_wren = 0;
  int unsigned a0, w0;

  localparam logic [63:0] D_CLEAN = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] D_VICT  = 64'hA5A5_0000_FFFF_1234;
  localparam logic [63:0] D_DIRTY = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D_SAME  = 64'hCAFE_F00D_1357_9BDF;

  dcache_line_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr), .victim_way(victim_way),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .miss_ack(miss_ack), .busy(busy), .err_way(err_way), .err_timeout(err_timeout),
    .bank_addr(bank_addr), .bank_way(bank_way), .bank_rden(bank_rden),
    .bank_mem_wren(bank_mem_wren), .bank_wrdata(bank_wrdata), .bank_line(bank_line),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Bank model: reset loads one known dirty victim line at set 3 way 2.
  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 8; s++)
        for (int w = 0; w < 3; w++)
          bankm[s][w] <= '0;
      bankm[3][2] <= D_VICT;
    end else if (bank_mem_wren && bank_way != 2'd3) begin
      bankm[bank_addr[5:3]][bank_way] <= bank_wrdata;
    end
  end

  always_comb begin
    bank_line = '0;
    if (bank_way != 2'd3) bank_line = bankm[bank_addr[5:3]][bank_way];
  end

  // Pulse counters for ack and bank writes.
  always @(posedge clk) begin
    if (miss_ack === 1'b1)      n_ack  <= n_ack + 1;
    if (bank_mem_wren === 1'b1) n_wren <= n_wren + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic request(input logic [14:0] a, input logic [1:0] w,
                         input logic d, input logic [8:0] t);
    miss_req     = 1'b1;
    miss_addr    = a;
    victim_way   = w;
    victim_dirty = d;
    victim_tag   = t;
  endtask

  initial begin
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0; victim_way = '0;
    victim_dirty = 1'b0; victim_tag = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_ack", miss_ack, 0);
    check("rst_errto", err_timeout, 0);
    check("rst_errway", err_way, 0);
    check("rst_memreq", mem_req, 0);
    check("rst_wren", bank_mem_wren, 0);
    check("rst_bankaddr", bank_addr, 0);
    check("rst_memaddr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wrdata", bank_wrdata, 0);
    rst = 1'b0;
    tick();

    // Clean miss: gnt first cycle, rvalid one cycle later, ack in cycle 4
    request(15'h0148, 2'd1, 1'b0, 9'h000);
    tick();                                   // cycle 1: FILL_REQ
    check("c_busy", busy, 1);
    check("c_req", mem_req, 1);
    check("c_we", mem_we, 0);
    check("c_maddr", mem_addr, 15'h0148);
    mem_gnt = 1'b1;
    tick();                                   // cycle 2: FILL_WAIT
    check("c_wait_req", mem_req, 0);
    check("c_wait_wren", bank_mem_wren, 0);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = D_CLEAN;
    tick();                                   // cycle 3: INSTALL
    check("c_wren", bank_mem_wren, 1);
    check("c_bway", bank_way, 1);
    check("c_baddr", bank_addr, 15'h0148);
    check("c_wrdata", bank_wrdata, D_CLEAN);
    check("c_ack_early", miss_ack, 0);
    mem_rvalid = 1'b0; mem_rdata = '0;
    tick();                                   // cycle 4: DONE
    check("c_ack", miss_ack, 1);
    check("c_wren_done", bank_mem_wren, 0);
    check("c_bank", bankm[1][1], D_CLEAN);
    miss_req = 1'b0;
    tick();
    check("c_idle_busy", busy, 0);
    check("c_idle_ack", miss_ack, 0);

    // Dirty miss: victim tag 1A5 set 3 way 2, ack in cycle 6
    request(15'h0898, 2'd2, 1'b1, 9'h1A5);
    tick();                                   // cycle 1: EVICT_RD
    check("d_rden", bank_rden, 1);
    check("d_baddr", bank_addr, 15'h6958);
    check("d_evict_req", mem_req, 0);
    tick();                                   // cycle 2: WB_REQ
    check("d_wb_req", mem_req, 1);
    check("d_wb_we", mem_we, 1);
    check("d_wb_addr", mem_addr, 15'h6958);
    check("d_wb_data", mem_wdata, D_VICT);
    check("d_wb_rden", bank_rden, 0);
    mem_gnt = 1'b1;
    tick();                                   // cycle 3: FILL_REQ
    check("d_fill_we", mem_we, 0);
    check("d_fill_addr", mem_addr, 15'h0898);
    check("d_fill_req", mem_req, 1);
    tick();                                   // cycle 4: FILL_WAIT
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = D_DIRTY;
    check("d_wait_req", mem_req, 0);
    tick();                                   // cycle 5: INSTALL
    mem_rvalid = 1'b0;
    check("d_wren", bank_mem_wren, 1);
    check("d_ins_addr", bank_addr, 15'h0898);
    check("d_ack_early", miss_ack, 0);
    tick();                                   // cycle 6: DONE
    check("d_ack", miss_ack, 1);
    check("d_bank", bankm[3][2], D_DIRTY);
    miss_req = 1'b0;
    tick();

    // Same-cycle gnt + rvalid: FILL_WAIT skipped, ack in cycle 3
    request(15'h7FF8, 2'd0, 1'b0, 9'h000);
    tick();                                   // cycle 1: FILL_REQ
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = D_SAME;
    tick();                                   // cycle 2: INSTALL
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("s_wren", bank_mem_wren, 1);
    check("s_wrdata", bank_wrdata, D_SAME);
    tick();                                   // cycle 3: DONE
    check("s_ack", miss_ack, 1);
    check("s_bank", bankm[7][0], D_SAME);
    miss_req = 1'b0;
    tick();
    check("ack_count", n_ack, 3);

    // Illegal victim way
    request(15'h0100, 2'd3, 1'b1, 9'h055);
    tick();
    check("w_err", err_way, 1);
    check("w_busy", busy, 0);
    check("w_req", mem_req, 0);
    check("w_rden", bank_rden, 0);
    miss_req = 1'b0;
    tick();
    check("w_err_pulse", err_way, 0);
    check("w_busy2", busy, 0);

    // Timeout: gnt never comes, MEM_TIMEOUT = 4
    a0 = n_ack; w0 = n_wren;
    request(15'h0100, 2'd0, 1'b0, 9'h000);
    tick();
    check("t_req1", mem_req, 1);
    miss_req = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("t_req_hold", mem_req, 1);
    end
    tick();
    check("t_req_drop", mem_req, 0);
    check("t_err", err_timeout, 1);
    check("t_busy", busy, 0);
    tick(); tick();
    check("t_sticky", err_timeout, 1);
    check("t_no_ack", n_ack, a0);
    check("t_no_wren", n_wren, w0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t_clr", err_timeout, 0);
    tick();

    // Reset while in FILL_WAIT, late rvalid must be ignored
    request(15'h0150, 2'd2, 1'b0, 9'h000);
    tick();                                   // FILL_REQ
    mem_gnt = 1'b1; miss_req = 1'b0;
    tick();                                   // FILL_WAIT
    check("r_wait_busy", busy, 1);
    a0 = n_ack; w0 = n_wren;
    mem_gnt = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_busy", busy, 0);
    check("r_bway", bank_way, 0);
    check("r_maddr", mem_addr, 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
    tick();
    mem_rvalid = 1'b0;
    tick(); tick();
    check("r_busy_late", busy, 0);
    check("r_no_wren", n_wren, w0);
    check("r_no_ack", n_ack, a0);
    check("r_bank", bankm[2][2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_line_ctrl.md
Name: dcache_line_ctrl

Overview:
- Memory-side line fill/evict engine for the 3-way, 8-set, 64-bit-line dcache data bank.
- On a miss it does two things:
  - Dirty victim: reads the victim line from the bank and writes it back to memory.
  - Every miss: fetches the missing line from memory and installs it with a full-line bank write (mem_wren).
- Sits between the dcache miss logic and the memory bus interface.
- It is the writer/reader counterpart of the bank's fill write port and its full-line read-out port.

Parameters:
MEM_TIMEOUT, 255, max cycles spent in any memory-wait state before abort (1..255; 8-bit counter)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
miss_req  in  1  miss request; sampled only in IDLE; held by requester until miss_ack
miss_addr  in  15  missing byte address; [14:6] tag, [5:3] set index
victim_way  in  2  way to replace, 0..2; 3 illegal
victim_dirty  in  1  victim line must be written back
victim_tag  in  9  tag of victim line
miss_ack  out  1  one-cycle pulse: line installed
busy  out  1  FSM not in IDLE
err_way  out  1  one-cycle pulse: request with victim_way==3 rejected
err_timeout  out  1  sticky until rst: memory wait exceeded MEM_TIMEOUT
bank_addr  out  15  {latched tag bits, index, 3'b000} to bank
bank_way  out  2  latched victim way
bank_rden  out  1  bank read enable (EVICT_RD only)
bank_mem_wren  out  1  full-line bank write (INSTALL only)
bank_wrdata  out  64  fill line to bank
bank_line  in  64  bank full-line output (full_out) of the selected way
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  1 = writeback, 0 = fill read
mem_addr  out  15  line-aligned address, [2:0]=0
mem_wdata  out  64  writeback data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  fill data valid this cycle
mem_rdata  in  64  fill data

Behaviour:
- Moore outputs: all outputs decode from the state register and latched registers and change only at the clk edge.
- Reset:
  - State = IDLE.
  - All 1-bit outputs = 0, including err_timeout.
  - bank_addr, bank_way, bank_wrdata, mem_addr, mem_wdata = 0.
- States and transitions:
  - IDLE:
    - If miss_req && victim_way==3: err_way=1 next cycle; stay in IDLE.
    - If miss_req && victim_way!=3: latch miss_addr, victim_way, victim_dirty, victim_tag; go to EVICT_RD if dirty, else FILL_REQ.
    - mem_rvalid and mem_gnt are ignored.
  - EVICT_RD (1 cycle):
    - bank_addr = {victim_tag[8:0], index, 3'b0}; bank_rden = 1.
    - bank_line is latched into the writeback buffer at the end of the cycle.
    - Next state: WB_REQ.
  - WB_REQ:
    - mem_req = 1, mem_we = 1, mem_addr = {victim_tag, index, 3'b0}, mem_wdata = buffer.
    - On mem_gnt: go to FILL_REQ.
  - FILL_REQ:
    - mem_req = 1, mem_we = 0, mem_addr = {miss_addr[14:3], 3'b0}.
    - mem_gnt && !mem_rvalid: go to FILL_WAIT.
    - mem_gnt && mem_rvalid: latch mem_rdata; go directly to INSTALL.
  - FILL_WAIT:
    - mem_req = 0.
    - On mem_rvalid: latch mem_rdata into bank_wrdata; go to INSTALL.
  - INSTALL (1 cycle):
    - bank_mem_wren = 1; bank_addr = {miss_addr[14:3], 3'b0}; bank_way and bank_wrdata held stable for the whole cycle.
    - Next state: DONE.
  - DONE (1 cycle):
    - miss_ack = 1.
    - Next state: IDLE, which does not re-accept the same request because the requester drops miss_req on seeing miss_ack.
- busy = 1 in every state except IDLE. miss_req outside IDLE is ignored.
- Latency, from the IDLE accept edge to miss_ack high, with gnt and rvalid arriving at their earliest:
  - Clean miss: 4 cycles (same-cycle gnt+rvalid: 3).
  - Dirty miss: 6 cycles.
- Timeout:
  - An 8-bit counter clears on entry to WB_REQ, FILL_REQ and FILL_WAIT, and increments each cycle spent in them.
  - When the counter reaches MEM_TIMEOUT: err_timeout is set (sticky), mem_req drops, FSM goes to IDLE with no miss_ack and no bank write.
- Reset mid-operation:
  - Any state returns to IDLE on the next edge.
  - In-flight memory responses arriving afterwards are ignored.
  - No partial bank write is ever issued, because bank_mem_wren occurs only in INSTALL.

Test Plan:
- Clean miss: miss_addr=15'h0148, way 1, dirty=0; mem_gnt on the first cycle; rvalid 1 cycle later with rdata=64'hDEADBEEF_01234567 -> mem_addr=15'h0148 with mem_we=0; one INSTALL cycle with bank_way=1 and bank_addr=15'h0148; miss_ack 4 cycles after accept; bank set 1 way 1 reads back the data.
- Dirty miss: victim_tag=9'h1A5, index 3, way 2, bank_line=64'hA5A5_0000_FFFF_1234 -> EVICT_RD, then writeback with mem_addr=15'h6958, mem_we=1, mem_wdata equal to bank_line; then fill; ack 6 cycles after accept.
- Same-cycle mem_gnt and mem_rvalid in FILL_REQ -> FILL_WAIT skipped, ack 3 cycles after accept (clean miss).
- victim_way=3 in IDLE -> err_way pulse for 1 cycle, busy stays 0, no mem_req.
- MEM_TIMEOUT=4, mem_gnt never asserted -> mem_req high 4 cycles, then err_timeout=1 and state IDLE; no miss_ack, no bank_mem_wren; err_timeout clears only on rst.
- rst asserted in FILL_WAIT, then mem_rvalid 2 cycles later -> outputs zero after the reset edge; no INSTALL, no miss_ack.
